// File: rtl/bus_rr_arbiter_if.sv
// Handshake and bus signals between the round-robin arbiter and its requesters/sink.
// The master modport is the arbiter side; slave is the requester/sink side.
interface bus_rr_arbiter_if #(
  parameter int BUS_SIZE  = 16,
  parameter int WORD_SIZE = 4,
  parameter int NUM_REQ   = 4
);
  localparam int PL_W = BUS_SIZE - 2 * WORD_SIZE;

  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*PL_W-1:0] payload_in;
  logic                    sink_ready;
  logic [NUM_REQ-1:0]      gnt;
  logic [NUM_REQ-1:0]      word_ack;
  logic [BUS_SIZE-1:0]     bus_data_out;
  logic                    bus_valid;
  logic                    pkt_done;
  logic [1:0]              state;

  modport master (
    input  req, payload_in, sink_ready,
    output gnt, word_ack, bus_data_out, bus_valid, pkt_done, state
  );

  modport slave (
    output req, payload_in, sink_ready,
    input  gnt, word_ack, bus_data_out, bus_valid, pkt_done, state
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin packet arbiter: grants one requester at a time and streams a
// WORD_NUM-word packet {all-ones header, live payload, sequence number} to a sink.
module bus_rr_arbiter #(
  parameter int BUS_SIZE  = 16,
  parameter int WORD_SIZE = 4,
  parameter int WORD_NUM  = 4,
  parameter int NUM_REQ   = 4
) (
  input  logic             clk,
  input  logic             reset,
  bus_rr_arbiter_if.master bus
);
  localparam int PL_W  = BUS_SIZE - 2 * WORD_SIZE;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [WORD_SIZE-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0]     cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]   cand_hit;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic                 accept;
  logic                 last_word;
  logic [IDX_W-1:0]     idx_plus1;

  // Candidate gi is the requester gi positions after the round-robin pointer.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum          = {1'b0, ptr_q} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                         : IDX_W'(sum);
      assign cand_hit[gi] = bus.req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && cand_hit[k]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  assign accept    = (state_q == SEND) && bus.sink_ready;
  assign last_word = (cnt_q == WORD_SIZE'(WORD_NUM - 1));
  assign idx_plus1 = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_found) begin
          gnt_d   = NUM_REQ'(1) << pick_idx;
          idx_d   = pick_idx;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // The granted requester's req is ignored here: a started packet always completes.
        if (accept) begin
          if (last_word) begin
            ptr_d   = idx_plus1;
            gnt_d   = '0;
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt          = gnt_q;
  assign bus.state        = state_q;
  assign bus.bus_valid    = (state_q == SEND);
  assign bus.word_ack     = accept ? gnt_q : '0;
  assign bus.pkt_done     = accept && last_word;
  assign bus.bus_data_out = (state_q == SEND)
                          ? {{WORD_SIZE{1'b1}}, bus.payload_in[idx_q*PL_W +: PL_W], cnt_q}
                          : '0;
endmodule
